int_ack_seq: RTL and testbench

CPU-side initiator of the maskable-interrupt acknowledge cycle.
- Samples nINT at instruction boundaries.
- Runs the M1+IORQ acknowledge bus cycle, including automatic and external wait states.
- Captures the byte the interrupting device drives on the data bus.
- Hands the captured byte to the execution core as an IM0 opcode, the IM1 fixed RST38 opcode, or an IM2 vector-table address.
- Sits between the bus pin logic and the instruction sequencer. It is the counterpart of the interrupt-responder device models used in simulation.

---
 rtl/z80_pkg.sv | 25 ++
 rtl/int_ack_seq_wait_ctr.sv | 33 +++
 rtl/int_ack_seq.sv | 117 +++++++++++
 tb/tb_int_ack_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/z80_pkg.sv
// Shared types and constants for the interrupt-acknowledge initiator.
package z80_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_TX,
        ST_T3,
        ST_DONE
    } int_ack_state_t;

    localparam logic [1:0] IM0 = 2'd0;
    localparam logic [1:0] IM1 = 2'd1;
    localparam logic [1:0] IM2 = 2'd2;

    localparam logic [7:0] RST38_OPCODE = 8'hFF;

    // Mode 3 is undefined on the core and behaves like mode 0.
    function automatic logic [1:0] map_mode(input logic [1:0] m);
        return (m == 2'd3) ? IM0 : m;
    endfunction

endpackage

// File: rtl/int_ack_seq_wait_ctr.sv
// Automatic wait-state down-counter; reports expiry split by the nWAIT level.
module ack_wait_ctr #(
    parameter int unsigned AUTO_WAITS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    input  logic nWAIT,
    output logic expired_go,
    output logic expired_hold
);

    localparam logic [1:0] LOAD_VAL = 2'(AUTO_WAITS);

    logic [1:0] count;
    logic       last;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count_en && !last) begin
            count <= count - 2'd1;
        end
    end

    assign last         = (count == 2'd1);
    assign expired_go   = last && nWAIT;
    assign expired_hold = last && !nWAIT;

endmodule

// File: rtl/int_ack_seq.sv
// Maskable-interrupt acknowledge initiator: M1+IORQ bus cycle, byte capture,
// and IM0/IM1/IM2 result hand-off to the execution core.
module int_ack_seq
    import z80_pkg::*;
#(
    parameter int unsigned AUTO_WAITS = 2,
    parameter logic [7:0]  IM1_OPCODE = RST38_OPCODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nINT,
    input  logic        nWAIT,
    input  logic        iff1,
    input  logic [1:0]  im,
    input  logic [7:0]  i_reg,
    input  logic        instr_end,
    input  logic [7:0]  db_in,
    output logic        nM1,
    output logic        nIORQ,
    output logic        int_taken,
    output logic        busy,
    output logic        ack_done,
    output logic [7:0]  ack_opcode,
    output logic [15:0] ack_vector,
    output logic [1:0]  ack_mode
);

    int_ack_state_t state, state_next;
    logic [7:0]     captured;
    logic           accept;
    logic           capture;
    logic           ctr_load;
    logic           ctr_go;
    logic           ctr_hold;

    ack_wait_ctr #(
        .AUTO_WAITS(AUTO_WAITS)
    ) u_wait_ctr (
        .clk         (clk),
        .reset       (reset),
        .load        (ctr_load),
        .count_en    (state == ST_TW),
        .nWAIT       (nWAIT),
        .expired_go  (ctr_go),
        .expired_hold(ctr_hold)
    );

    // Gated by reset so no acceptance pulse escapes while the state is held.
    assign accept = (state == ST_IDLE) && instr_end && !nINT && iff1 && !reset;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        ctr_load   = 1'b0;
        nM1        = 1'b1;
        nIORQ      = 1'b1;
        int_taken  = accept;
        busy       = (state != ST_IDLE);
        ack_done   = (state == ST_DONE);
        case (state)
            ST_IDLE: if (accept) state_next = ST_T1;
            ST_T1: begin
                nM1        = 1'b0;
                state_next = ST_T2;
            end
            ST_T2: begin
                nM1        = 1'b0;
                ctr_load   = 1'b1;
                state_next = ST_TW;
            end
            ST_TW: begin
                nM1   = 1'b0;
                nIORQ = 1'b0;
                if (ctr_go) begin
                    capture    = 1'b1;
                    state_next = ST_T3;
                end else if (ctr_hold) begin
                    state_next = ST_TX;
                end
            end
            ST_TX: begin
                nM1   = 1'b0;
                nIORQ = 1'b0;
                if (nWAIT) begin
                    capture    = 1'b1;
                    state_next = ST_T3;
                end
            end
            ST_T3:   state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            captured   <= '0;
            ack_opcode <= '0;
            ack_vector <= '0;
            ack_mode   <= IM0;
        end else begin
            state <= state_next;
            if (accept) ack_mode <= map_mode(im);
            if (capture) captured <= db_in;
            // Results land at the end of T3 so they are stable during DONE.
            if (state == ST_T3) begin
                case (ack_mode)
                    IM1:     ack_opcode <= IM1_OPCODE;
                    IM2:     ack_vector <= {i_reg, captured};
                    default: ack_opcode <= captured;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_int_ack_seq.sv
// Directed bench for int_ack_seq with a queue of expected acknowledge results.
module tb_int_ack_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        nINT;
    logic        nWAIT;
    logic        iff1;
    logic [1:0]  im;
    logic [7:0]  i_reg;
    logic        instr_end;
    logic [7:0]  db_in;
    logic [7:0]  resp;
    logic        nM1;
    logic        nIORQ;
    logic        int_taken;
    logic        busy;
    logic        ack_done;
    logic [7:0]  ack_opcode;
    logic [15:0] ack_vector;
    logic [1:0]  ack_mode;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  op;
        logic [15:0] vec;
        int          lat;
        int          iorq;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  m_op  = 8'h00;
    logic [15:0] m_vec = 16'h0000;
    int          total = 0;
    int          bad   = 0;

    int_ack_seq #(
        .AUTO_WAITS(2),
        .IM1_OPCODE(8'hFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .nINT      (nINT),
        .nWAIT     (nWAIT),
        .iff1      (iff1),
        .im        (im),
        .i_reg     (i_reg),
        .instr_end (instr_end),
        .db_in     (db_in),
        .nM1       (nM1),
        .nIORQ     (nIORQ),
        .int_taken (int_taken),
        .busy      (busy),
        .ack_done  (ack_done),
        .ack_opcode(ack_opcode),
        .ack_vector(ack_vector),
        .ack_mode  (ack_mode)
    );

    always #5 clk = ~clk;

    // Responder drives its byte only while both strobes are low.
    assign db_in = (!nM1 && !nIORQ) ? resp : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] mode_in, input logic [7:0] ireg,
                            input logic [7:0] b, input int nw);
        exp_t       e;
        logic [1:0] m;
        m = (mode_in == 2'd3) ? 2'd0 : mode_in;
        case (m)
            2'd1:    m_op  = 8'hFF;
            2'd2:    m_vec = {ireg, b};
            default: m_op  = b;
        endcase
        e.mode = m;
        e.op   = m_op;
        e.vec  = m_vec;
        e.lat  = 6 + nw;
        e.iorq = 2 + nw;
        sb.push_back(e);
    endtask

    task automatic run_ack(input logic [1:0] mode_in, input logic [7:0] ireg,
                           input logic [7:0] b, input int nw);
        int   iorq_cnt;
        int   spurious;
        int   lat;
        logic seen;
        exp_t e;
        push_exp(mode_in, ireg, b, nw);
        @(posedge clk); #1;
        im = mode_in; i_reg = ireg; resp = b;
        nINT = 1'b0; iff1 = 1'b1; instr_end = 1'b1; nWAIT = 1'b1;
        @(negedge clk);
        check("int_taken", 32'(int_taken), 32'd1);
        iorq_cnt = 0; spurious = 0; lat = 0; seen = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(posedge clk); #1;
            // A second instr_end with nINT low mid-cycle must be ignored.
            instr_end = (c == 3);
            nINT      = (c == 3) ? 1'b0 : 1'b1;
            nWAIT     = !(c >= 4 && c < 4 + nw);
            @(negedge clk);
            if (!nIORQ) iorq_cnt++;
            if (int_taken) spurious++;
            if (ack_done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        e = sb.pop_front();
        check("ack_done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(e.lat));
        check("iorq_clocks", 32'(iorq_cnt), 32'(e.iorq));
        check("spurious_int_taken", 32'(spurious), 32'd0);
        check("ack_opcode", 32'(ack_opcode), 32'(e.op));
        check("ack_vector", 32'(ack_vector), 32'(e.vec));
        check("ack_mode", 32'(ack_mode), 32'(e.mode));
        check("busy_at_done", 32'(busy), 32'd1);
        check("nM1_at_done", 32'(nM1), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("ack_done_width", 32'(ack_done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int strobe_cnt;
        int done_cnt;
        reset = 1'b1; nINT = 1'b1; nWAIT = 1'b1; iff1 = 1'b0; instr_end = 1'b0;
        im = 2'd0; i_reg = 8'h00; resp = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_nM1", 32'(nM1), 32'd1);
        check("rst_nIORQ", 32'(nIORQ), 32'd1);
        check("rst_int_taken", 32'(int_taken), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack_done", 32'(ack_done), 32'd0);
        check("rst_ack_opcode", 32'(ack_opcode), 32'h00);
        check("rst_ack_vector", 32'(ack_vector), 32'h0000);
        check("rst_ack_mode", 32'(ack_mode), 32'd0);

        run_ack(2'd2, 8'h12, 8'h80, 0);
        run_ack(2'd0, 8'h12, 8'hFF, 0);
        run_ack(2'd0, 8'h12, 8'hC7, 0);
        run_ack(2'd1, 8'h12, 8'h55, 0);
        run_ack(2'd3, 8'h34, 8'h3C, 0);

        // Interrupts disabled: request must be ignored.
        @(posedge clk); #1;
        nINT = 1'b0; iff1 = 1'b0; instr_end = 1'b1;
        @(negedge clk);
        check("iff1_off_int_taken", 32'(int_taken), 32'd0);
        strobe_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            instr_end = (c % 4 == 0);
            @(negedge clk);
            if (!nM1 || !nIORQ || busy || int_taken) strobe_cnt++;
        end
        check("iff1_off_strobes", 32'(strobe_cnt), 32'd0);
        nINT = 1'b1; instr_end = 1'b0;

        run_ack(2'd2, 8'hA5, 8'h0E, 3);

        // Reset during TW aborts the cycle and releases the strobes.
        @(posedge clk); #1;
        im = 2'd0; resp = 8'h99; nINT = 1'b0; iff1 = 1'b1; instr_end = 1'b1; nWAIT = 1'b1;
        @(negedge clk);
        check("rstmid_int_taken", 32'(int_taken), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            instr_end = 1'b0; nINT = 1'b1;
            if (c == 3) reset = 1'b1;
            @(negedge clk);
        end
        check("rstmid_in_tw_nIORQ", 32'(nIORQ), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_nM1", 32'(nM1), 32'd1);
        check("rstmid_nIORQ", 32'(nIORQ), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_ack_opcode", 32'(ack_opcode), 32'h00);
        check("rstmid_ack_vector", 32'(ack_vector), 32'h0000);
        check("rstmid_ack_mode", 32'(ack_mode), 32'd0);
        m_op  = 8'h00;
        m_vec = 16'h0000;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack_done || busy) done_cnt++;
        end
        check("rstmid_no_ack_done", 32'(done_cnt), 32'd0);

        run_ack(2'd0, 8'h00, 8'h21, 0);
        run_ack(2'd2, 8'h7E, 8'h42, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
